// File: rtl/sbc_pkg.sv
// Shared definitions for serial_bit_conditioner: debounce FSM encoding and
// synchronizer depth.
package sbc_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_PEND   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_PEND = 2'b11
    } sbc_state_e;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sbc_sync2.sv
// Two-flop synchronizer for one asynchronous level input; runs whenever
// rst_n is high, independent of any enable.
module sbc_sync2
    import sbc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/serial_bit_conditioner.sv
// Debounced push-button strobe that captures one serial data bit per press.
// Optional bit history shift register is built only with SBC_BIT_HISTORY_EN.
//
// state        | meaning
// RELEASED     | button idle, waiting for strobe high
// PRESS_PEND   | strobe high, counting stable cycles before accepting press
// PRESSED      | press accepted, waiting for strobe low
// RELEASE_PEND | strobe low, counting stable cycles before accepting release
module serial_bit_conditioner
    import sbc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       data_in,
    input  logic       strobe_in,
    output logic       bit_valid,
    output logic       bit_out,
    output logic [2:0] bit_count,
    output logic [7:0] history
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic data_s;
    logic strobe_s;

    sbc_sync2 u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (data_in),
        .q_o   (data_s)
    );

    sbc_sync2 u_sync_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (strobe_in),
        .q_o   (strobe_s)
    );

    sbc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             bit_q, bit_d;
    logic [2:0]       count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
            count_q <= count_d;
        end
    end

    // The counter is cleared on every state change, so it never exceeds CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        bit_d   = bit_q;
        count_d = count_q;
        if (ena) begin
            case (state_q)
                RELEASED: begin
                    if (strobe_s) begin
                        state_d = PRESS_PEND;
                        cnt_d   = '0;
                    end
                end
                PRESS_PEND: begin
                    if (!strobe_s) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        bit_d   = data_s;
                        count_d = count_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!strobe_s) begin
                        state_d = RELEASE_PEND;
                        cnt_d   = '0;
                    end
                end
                RELEASE_PEND: begin
                    if (strobe_s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bit_valid = valid_q;
    assign bit_out   = bit_q;
    assign bit_count = count_q;

`ifdef SBC_BIT_HISTORY_EN
    logic [7:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (valid_d) begin
            hist_d = {hist_q[6:0], bit_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 8'h00;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign history = hist_q;
`else
    assign history = 8'h00;
`endif

endmodule

// File: tb/tb_serial_bit_conditioner.sv
// Directed self-checking bench for serial_bit_conditioner with DEBOUNCE_CYCLES=4.
module tb_serial_bit_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       data_in;
    logic       strobe_in;
    logic       bit_valid;
    logic       bit_out;
    logic [2:0] bit_count;
    logic [7:0] history;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pattern = 8'b10110010;
    logic [7:0] exp_hist;

    serial_bit_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .strobe_in (strobe_in),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_count (bit_count),
        .history   (history)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold strobe at s_val for n_edges clocks; bit_valid must be high only
    // after edge valid_at (0 = never), edges counted from 1.
    task automatic watch(input string tag, input logic s_val, input int n_edges, input int valid_at);
        strobe_in = s_val;
        for (int k = 1; k <= n_edges; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_e%0d", tag, k), {7'd0, bit_valid}, (k == valid_at) ? 8'd1 : 8'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        data_in   = 1'b0;
        strobe_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {7'd0, bit_valid}, 8'd0);
        check("rst_bit", {7'd0, bit_out}, 8'd0);
        check("rst_count", {5'd0, bit_count}, 8'd0);
        check("rst_hist", history, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Clean press: valid after edge 7, nothing else while held or released
        data_in = 1'b1;
        watch("clean", 1'b1, 20, 7);
        check("clean_bit", {7'd0, bit_out}, 8'd1);
        check("clean_count", {5'd0, bit_count}, 8'd1);
        watch("clean_rel", 1'b0, 12, 0);

        // Bounce 1,0,1,0 then hold: valid 7 edges into the final hold (6 after its sampling edge)
        data_in = 1'b0;
        watch("b1", 1'b1, 1, 0);
        watch("b2", 1'b0, 1, 0);
        watch("b3", 1'b1, 1, 0);
        watch("b4", 1'b0, 1, 0);
        watch("bounce", 1'b1, 20, 7);
        check("bounce_bit", {7'd0, bit_out}, 8'd0);
        check("bounce_count", {5'd0, bit_count}, 8'd2);
        watch("bounce_rel", 1'b0, 12, 0);

        // ena low for 10 edges in PRESS_PEND (cnt=1); 3 more edges after return
        data_in = 1'b1;
        watch("ena_a", 1'b1, 4, 0);
        ena = 1'b0;
        watch("ena_off", 1'b1, 10, 0);
        check("ena_off_count", {5'd0, bit_count}, 8'd2);
        ena = 1'b1;
        watch("ena_on", 1'b1, 10, 3);
        check("ena_bit", {7'd0, bit_out}, 8'd1);
        check("ena_count", {5'd0, bit_count}, 8'd3);
        watch("ena_rel", 1'b0, 12, 0);

        // Reset mid-PRESS_PEND discards the press
        data_in = 1'b0;
        watch("rp_a", 1'b1, 4, 0);
        rst_n = 1'b0;
        #1;
        check("rp_valid", {7'd0, bit_valid}, 8'd0);
        check("rp_bit", {7'd0, bit_out}, 8'd0);
        check("rp_count", {5'd0, bit_count}, 8'd0);
        check("rp_hist", history, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch("rp_hold", 1'b1, 3, 0);
        watch("rp_rel", 1'b0, 15, 0);
        check("rp_count2", {5'd0, bit_count}, 8'd0);

        // Eight presses 1,0,1,1,0,0,1,0
        for (int i = 0; i < 8; i++) begin
            data_in = pattern[7-i];
            watch($sformatf("p%0d", i), 1'b1, 10, 7);
            check($sformatf("p%0d_bit", i), {7'd0, bit_out}, {7'd0, pattern[7-i]});
            check($sformatf("p%0d_count", i), {5'd0, bit_count}, 8'((i + 1) % 8));
            watch($sformatf("p%0d_rel", i), 1'b0, 12, 0);
        end
`ifdef SBC_BIT_HISTORY_EN
        exp_hist = 8'b10110010;
`else
        exp_hist = 8'h00;
`endif
        check("final_count", {5'd0, bit_count}, 8'd0);
        check("final_hist", history, exp_hist);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_bit_conditioner.md
SERIAL_BIT_CONDITIONER -- requirements
Module: serial_bit_conditioner

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles needed to accept a strobe level change (legal range 1..65535).
REQ-002 The block SHALL provide port clk  input  1  single clock for all state.
REQ-003 The block SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL provide port ena  input  1  design enable; high = block operates.
REQ-005 The block SHALL provide port data_in  input  1  asynchronous serial data switch level.
REQ-006 The block SHALL provide port strobe_in  input  1  asynchronous, bouncy push-button strobe.
REQ-007 The block SHALL provide port bit_valid  output  1  one-cycle pulse marking an accepted bit.
REQ-008 The block SHALL provide port bit_out  output  1  accepted bit value; stable until the next bit_valid.
REQ-009 The block SHALL provide port bit_count  output  3  count of accepted bits, modulo 8.
REQ-010 The block SHALL provide port history  output  8  last eight accepted bits, newest in bit 0.

Function
REQ-011 data_in and strobe_in SHALL each pass through a two-flop synchronizer that runs whenever rst_n is high, regardless of ena.
REQ-012 The debouncer SHALL be a four-state FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-013 RELEASED -> PRESS_PEND when the synchronized strobe is 1; PRESS_PEND -> PRESSED after DEBOUNCE_CYCLES consecutive cycles at 1; PRESS_PEND -> RELEASED on any 0.
REQ-014 PRESSED -> RELEASE_PEND when the synchronized strobe is 0; RELEASE_PEND -> RELEASED after DEBOUNCE_CYCLES consecutive cycles at 0; RELEASE_PEND -> PRESSED on any 1.
REQ-015 The stability counter SHALL be sized to hold DEBOUNCE_CYCLES, clear on every state entry, and never wrap.
REQ-016 On the PRESS_PEND -> PRESSED transition the block SHALL register bit_valid = 1 for exactly one cycle and register bit_out from the synchronized data_in sampled on that same edge.
REQ-017 Latency: a clean strobe_in rise SHALL produce bit_valid high in the cycle following rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples strobe_in high as edge 1.
REQ-018 Exactly one bit_valid SHALL be produced per debounced press; a held press and a release SHALL produce none.
REQ-019 bit_count SHALL increment by 1 on each bit_valid and wrap from 7 to 0.
REQ-020 With ena low, FSM, counter, bit_count and history SHALL hold their values and bit_valid SHALL be 0; on ena rising, operation resumes from the held state.
REQ-021 bit_valid SHALL be a registered output with no combinational path from any input.

Reset
REQ-022 While rst_n is low: synchronizer flops 0, FSM RELEASED, counter 0, bit_valid 0, bit_out 0, bit_count 0, history 8'h00.
REQ-023 Reset asserted mid-debounce SHALL discard the pending press; no bit_valid SHALL follow the release of reset until a fresh full debounce completes.

Configuration
REQ-024 With macro SBC_BIT_HISTORY_EN defined, history SHALL be an 8-bit shift register loading {history[6:0], bit_out_next} on each bit_valid.
REQ-025 Without SBC_BIT_HISTORY_EN, history SHALL be tied to 8'h00, no history flops SHALL be inferred, and all other behaviour SHALL be unchanged.

Structure
REQ-026 A shared package sbc_pkg SHALL hold the FSM state encoding (RELEASED=2'b00, PRESS_PEND=2'b01, PRESSED=2'b10, RELEASE_PEND=2'b11) and the synchronizer depth constant (2).
REQ-027 The two-flop synchronizer SHALL be a sub-module named sbc_sync2, instantiated once per asynchronous input.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Clean press, data_in=1, strobe held high 20 cycles -> one bit_valid 7 cycles after the first edge sampling strobe high, with bit_out=1 and bit_count=1.
REQ-029 Bounce: strobe toggles 1,0,1,0 on single cycles, then holds 1 -> exactly one bit_valid, 7 cycles after the final rise.
REQ-030 Eight presses with data 1,0,1,1,0,0,1,0 -> bit_count returns to 0; with SBC_BIT_HISTORY_EN, history=8'b10110010; without it, history=8'h00.
REQ-031 ena dropped for 10 cycles during PRESS_PEND with strobe high -> no bit_valid while ena is low; bit_valid fires after the remaining stable cycles once ena returns.
REQ-032 rst_n pulsed low during PRESS_PEND, strobe still high -> outputs at reset values, no bit_valid until strobe releases and a new press debounces.
